// File: rtl/buzz_arbiter_pkg.sv
// Package for the buzzer arbiter: FSM state codes, tone codes, grant codes
// and a small constant helper used to size the duration counter.
package buzz_arbiter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_KEY    = 3'd1;
  localparam state_t ST_CHIME  = 3'd2;
  localparam state_t ST_ALARM  = 3'd3;
  localparam state_t ST_SNOOZE = 3'd4;
  localparam state_t ST_GAP    = 3'd5;

  typedef enum logic [1:0] {
    TONE_NONE  = 2'd0,
    TONE_KEY   = 2'd1,
    TONE_CHIME = 2'd2,
    TONE_ALARM = 2'd3
  } tone_t;

  localparam logic [2:0] GRANT_KEY   = 3'b001;
  localparam logic [2:0] GRANT_CHIME = 3'b010;
  localparam logic [2:0] GRANT_ALARM = 3'b100;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/buzz_arbiter_if.sv
// Request/response bundle between the clock controller and the buzzer arbiter.
//   alarm_req  level : alarm matched and enabled
//   chime_req  pulse : hourly chime
//   key_req    pulse : debounced key press
//   snooze     pulse : snooze key
//   buzz_en    player enable
//   tone_sel   0 none, 1 key, 2 chime, 3 alarm
//   grant      one-hot {alarm,chime,key}
//   busy       arbiter not idle
interface buzz_arbiter_if;
  logic       alarm_req;
  logic       chime_req;
  logic       key_req;
  logic       snooze;
  logic       buzz_en;
  logic [1:0] tone_sel;
  logic [2:0] grant;
  logic       busy;

  modport master (
    output alarm_req, chime_req, key_req, snooze,
    input  buzz_en, tone_sel, grant, busy
  );

  modport slave (
    input  alarm_req, chime_req, key_req, snooze,
    output buzz_en, tone_sel, grant, busy
  );
endinterface

// File: rtl/buzz_arbiter_tick_gen.sv
// Restartable tick divider.
//   clk, rst  clock, async active-high reset
//   restart   forces the divider back to 0 on the next clock
//   tick      one-clock pulse while the divider sits at TICK_DIV-1
module buzz_arbiter_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div <= '0;
    else if (restart || tick)
      div <= '0;
    else
      div <= div + 1'b1;
  end

endmodule

// File: rtl/buzz_arbiter.sv
// Shares the piezo buzzer between alarm, hourly chime and key beep.
// Priority alarm > chime > key, with minimum on-times, snooze, alarm
// timeout/lockout and a forced gap after key/chime grants.
//   clk, rst  clock, async active-high reset
//   bus       buzz_arbiter_if slave: requests in, player controls out
//
// state  | meaning
// IDLE   | silent, arbitrating pending requests
// KEY    | key beep playing
// CHIME  | chime playing
// ALARM  | alarm playing, bounded by ALARM_TICKS
// SNOOZE | alarm silenced for SNOOZE_TICKS
// GAP    | forced silence after a key/chime grant
module buzz_arbiter
  import buzz_arbiter_pkg::*;
#(
  parameter int TICK_DIV     = 500000,
  parameter int KEY_TICKS    = 5,
  parameter int CHIME_TICKS  = 100,
  parameter int ALARM_TICKS  = 6000,
  parameter int SNOOZE_TICKS = 30000,
  parameter int GAP_TICKS    = 10
) (
  input  logic     clk,
  input  logic     rst,
  buzz_arbiter_if.slave bus
);

  localparam int MAX_T = max_of(max_of(max_of(KEY_TICKS, CHIME_TICKS),
                                       max_of(ALARM_TICKS, SNOOZE_TICKS)), GAP_TICKS);
  localparam int DUR_W = $clog2(MAX_T + 1);

  localparam logic [DUR_W-1:0] KEY_N    = DUR_W'(KEY_TICKS);
  localparam logic [DUR_W-1:0] CHIME_N  = DUR_W'(CHIME_TICKS);
  localparam logic [DUR_W-1:0] ALARM_N  = DUR_W'(ALARM_TICKS);
  localparam logic [DUR_W-1:0] SNOOZE_N = DUR_W'(SNOOZE_TICKS);
  localparam logic [DUR_W-1:0] GAP_N    = DUR_W'(GAP_TICKS);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  state_t           state, state_next;
  logic [DUR_W-1:0] dur, dur_load;
  logic             chime_pend, key_pend, lock;
  logic             tick, restart, dur_end, timeout;
  logic             alarm_go, in_alarm, grant_chime, grant_key;

  buzz_arbiter_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign alarm_go = bus.alarm_req && !lock;
  assign in_alarm = (state == ST_ALARM) || (state == ST_SNOOZE);
  assign dur_end  = tick && (dur == DUR_ONE);
  // SNOOZE->ALARM is a state change too, so the alarm budget is reloaded in full.
  assign restart  = (state_next != state);

  // Raw pulses are OR'ed in so a request granted in its own clock is consumed once.
  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (alarm_go)                          state_next = ST_ALARM;
        else if (chime_pend || bus.chime_req)  state_next = ST_CHIME;
        else if (key_pend || bus.key_req)      state_next = ST_KEY;
      end
      ST_KEY, ST_CHIME, ST_GAP: begin
        if (alarm_go)      state_next = ST_ALARM;
        else if (dur_end)  state_next = (state == ST_GAP) ? ST_IDLE : ST_GAP;
      end
      ST_ALARM: begin
        if (!bus.alarm_req)  state_next = ST_IDLE;
        else if (bus.snooze) state_next = ST_SNOOZE;
        else if (dur_end) begin
          state_next = ST_IDLE;
          timeout    = 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (!bus.alarm_req) state_next = ST_IDLE;
        else if (dur_end)   state_next = ST_ALARM;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dur_load = '0;
    case (state_next)
      ST_KEY:    dur_load = KEY_N;
      ST_CHIME:  dur_load = CHIME_N;
      ST_ALARM:  dur_load = ALARM_N;
      ST_SNOOZE: dur_load = SNOOZE_N;
      ST_GAP:    dur_load = GAP_N;
      default:   dur_load = '0;
    endcase
  end

  assign grant_chime = restart && (state_next == ST_CHIME);
  assign grant_key   = restart && (state_next == ST_KEY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dur        <= '0;
      chime_pend <= 1'b0;
      key_pend   <= 1'b0;
      lock       <= 1'b0;
    end else begin
      state <= state_next;
      if (restart)
        dur <= dur_load;
      else if (tick && (dur != '0))
        dur <= dur - 1'b1;
      chime_pend <= (chime_pend || bus.chime_req) && !grant_chime;
      // Key beeps are pointless once the alarm owns the buzzer, so drop them.
      key_pend   <= (key_pend || (bus.key_req && !in_alarm)) && !grant_key;
      if (timeout)
        lock <= 1'b1;
      else if (!bus.alarm_req)
        lock <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.buzz_en  <= 1'b0;
      bus.tone_sel <= TONE_NONE;
      bus.grant    <= '0;
    end else begin
      bus.buzz_en  <= 1'b0;
      bus.tone_sel <= TONE_NONE;
      bus.grant    <= '0;
      case (state)
        ST_KEY: begin
          bus.buzz_en  <= 1'b1;
          bus.tone_sel <= TONE_KEY;
          bus.grant    <= GRANT_KEY;
        end
        ST_CHIME: begin
          bus.buzz_en  <= 1'b1;
          bus.tone_sel <= TONE_CHIME;
          bus.grant    <= GRANT_CHIME;
        end
        ST_ALARM: begin
          bus.buzz_en  <= 1'b1;
          bus.tone_sel <= TONE_ALARM;
          bus.grant    <= GRANT_ALARM;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_buzz_arbiter.sv
// Scoreboard bench for buzz_arbiter with short timing parameters
// (TICK_DIV=4, KEY=2, CHIME=3, ALARM=5, SNOOZE=4, GAP=1).
// Per-clock expected {grant, busy} entries are queued as stimulus is driven
// and popped at each falling edge; tone and enable are derived from grant.
module tb_buzz_arbiter;

  logic clk = 1'b0;
  logic rst;

  buzz_arbiter_if bus ();

  buzz_arbiter #(
    .TICK_DIV     (4),
    .KEY_TICKS    (2),
    .CHIME_TICKS  (3),
    .ALARM_TICKS  (5),
    .SNOOZE_TICKS (4),
    .GAP_TICKS    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] grant;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    if (got == want)
      n_pass++;
    else
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
  endtask

  function automatic int tone_of(input logic [2:0] g);
    case (g)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 3;
      default: return 0;
    endcase
  endfunction

  task automatic expect_run(input string tag, input logic [2:0] g, input logic b, input int n);
    exp_t e;
    e.grant = g;
    e.busy  = b;
    e.tag   = tag;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // One entry per falling edge; pulses driven before the call last one clock.
  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      @(negedge clk);
      e = sb.pop_front();
      check_val({e.tag, "_grant"}, int'(bus.grant),    int'(e.grant));
      check_val({e.tag, "_tone"},  int'(bus.tone_sel), tone_of(e.grant));
      check_val({e.tag, "_en"},    int'(bus.buzz_en),  int'(e.grant != 3'b000));
      check_val({e.tag, "_busy"},  int'(bus.busy),     int'(e.busy));
      bus.key_req   = 1'b0;
      bus.chime_req = 1'b0;
      bus.snooze    = 1'b0;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.alarm_req = 1'b0;
    bus.chime_req = 1'b0;
    bus.key_req   = 1'b0;
    bus.snooze    = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_grant", int'(bus.grant),    0);
    check_val("rst_tone",  int'(bus.tone_sel), 0);
    check_val("rst_en",    int'(bus.buzz_en),  0);
    check_val("rst_busy",  int'(bus.busy),     0);
    rst = 1'b0;
    expect_run("idle", 3'b000, 1'b0, 2);
    drain();

    // Single key beep: 8 clks on, then GAP (4 clks) ending in IDLE.
    bus.key_req = 1'b1;
    expect_run("key_lat",  3'b000, 1'b1, 1);
    expect_run("key_on",   3'b001, 1'b1, 8);
    expect_run("key_gap",  3'b000, 1'b1, 3);
    expect_run("key_idle", 3'b000, 1'b0, 1);
    drain();

    // Chime and key together: chime wins, key follows after GAP plus one
    // arbitration clock in IDLE (silence of 5 clks at the outputs).
    bus.chime_req = 1'b1;
    bus.key_req   = 1'b1;
    expect_run("ck_lat",   3'b000, 1'b1, 1);
    expect_run("ck_chime", 3'b010, 1'b1, 12);
    expect_run("ck_gap",   3'b000, 1'b1, 3);
    expect_run("ck_idle",  3'b000, 1'b0, 1);
    expect_run("ck_klat",  3'b000, 1'b1, 1);
    expect_run("ck_key",   3'b001, 1'b1, 8);
    expect_run("ck_gap2",  3'b000, 1'b1, 3);
    expect_run("ck_end",   3'b000, 1'b0, 1);
    drain();

    // Alarm preempts a key beep, runs 20 clks, then locks out while held.
    bus.key_req = 1'b1;
    expect_run("pre_lat", 3'b000, 1'b1, 1);
    expect_run("pre_key", 3'b001, 1'b1, 2);
    drain();
    bus.alarm_req = 1'b1;
    expect_run("pre_keyl",  3'b001, 1'b1, 1);
    expect_run("alm_on",    3'b100, 1'b1, 19);
    expect_run("alm_last",  3'b100, 1'b0, 1);
    expect_run("alm_lock",  3'b000, 1'b0, 10);
    drain();

    // Drop for one clock to clear the lock, re-raise, snooze, resume.
    bus.alarm_req = 1'b0;
    expect_run("unlock", 3'b000, 1'b0, 1);
    drain();
    bus.alarm_req = 1'b1;
    expect_run("alm2_lat", 3'b000, 1'b1, 1);
    expect_run("alm2_on",  3'b100, 1'b1, 3);
    drain();
    bus.snooze = 1'b1;
    expect_run("snz_lat", 3'b100, 1'b1, 1);
    expect_run("snz_off", 3'b000, 1'b1, 16);
    expect_run("snz_res", 3'b100, 1'b1, 3);
    drain();
    // Chime during ALARM stays pending; key during ALARM is dropped.
    bus.chime_req = 1'b1;
    bus.key_req   = 1'b1;
    expect_run("res_on",    3'b100, 1'b1, 16);
    expect_run("res_last",  3'b100, 1'b0, 1);
    expect_run("pch_lat",   3'b000, 1'b1, 1);
    expect_run("pch_on",    3'b010, 1'b1, 12);
    expect_run("pch_gap",   3'b000, 1'b1, 3);
    expect_run("nokey",     3'b000, 1'b0, 5);
    drain();
    bus.alarm_req = 1'b0;
    expect_run("quiet", 3'b000, 1'b0, 3);
    drain();

    // Reset mid-chime with chime and key pending: everything is lost.
    bus.chime_req = 1'b1;
    expect_run("rc_lat", 3'b000, 1'b1, 1);
    expect_run("rc_on",  3'b010, 1'b1, 3);
    drain();
    bus.chime_req = 1'b1;
    bus.key_req   = 1'b1;
    expect_run("rc_on2", 3'b010, 1'b1, 1);
    drain();
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_grant", int'(bus.grant),    0);
    check_val("mid_rst_tone",  int'(bus.tone_sel), 0);
    check_val("mid_rst_en",    int'(bus.buzz_en),  0);
    check_val("mid_rst_busy",  int'(bus.busy),     0);
    @(negedge clk);
    rst = 1'b0;
    expect_run("post_rst", 3'b000, 1'b0, 12);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
